// File: rtl/match_scheduler.sv
// Batch sequencer for the string-matching PE array: loads weights into PE slots,
// scans every string per batch, OR-accumulates slot hits and emits one masked result word.
module match_scheduler #(
  parameter int weight_num           = 23331,
  parameter int string_num           = 25,
  parameter int strlen               = 150,
  parameter int groups               = 4,
  parameter int num                  = 4,
  parameter int max_number_of_weight = num * groups,
  parameter int WIDX_W = (weight_num > 1) ? $clog2(weight_num) : 1,
  parameter int SLOT_W = (max_number_of_weight > 1) ? $clog2(max_number_of_weight) : 1,
  parameter int STR_W  = (string_num > 1) ? $clog2(string_num) : 1,
  parameter int BAT_W  = (((weight_num + max_number_of_weight - 1) / max_number_of_weight) > 1)
                         ? $clog2((weight_num + max_number_of_weight - 1) / max_number_of_weight) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            error,
  output logic                            wt_valid,
  input  logic                            wt_ready,
  output logic [WIDX_W-1:0]               wt_idx,
  output logic [SLOT_W-1:0]               wt_slot,
  output logic                            pe_start,
  output logic [STR_W-1:0]                str_idx,
  input  logic                            pe_done,
  input  logic [max_number_of_weight-1:0] pe_hit,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [BAT_W-1:0]                res_batch,
  output logic [max_number_of_weight-1:0] res_data,
  output logic [max_number_of_weight-1:0] res_mask
);

  localparam int MAXW       = max_number_of_weight;
  localparam int NUM_BATCH  = (weight_num + MAXW - 1) / MAXW;
  localparam int LAST_FILL  = weight_num - (NUM_BATCH - 1) * MAXW;
  localparam int WDOG_LIMIT = strlen + 8;
  localparam int WDOG_W     = $clog2(WDOG_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SCAN,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [BAT_W-1:0]  batch_q;
  logic [SLOT_W-1:0] slot_q;
  logic [STR_W-1:0]  str_q;
  logic [WDOG_W-1:0] wdog_q;
  logic [MAXW-1:0]   acc_q;
  logic [WIDX_W-1:0] wt_idx_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;
  logic              wt_valid_q;
  logic              pe_start_q;
  logic              res_valid_q;
  logic [MAXW-1:0]   res_data_q;
  logic [MAXW-1:0]   res_mask_q;

  logic              last_batch;
  logic [SLOT_W-1:0] last_slot;
  logic [MAXW-1:0]   batch_mask;
  logic              wdog_expired;
  logic              scan_end;
  logic [MAXW-1:0]   scan_hit;
  logic [MAXW-1:0]   acc_next;

  // Only the final batch can be partially filled; every earlier batch uses all slots.
  always_comb begin
    batch_mask   = '0;
    last_batch   = (batch_q == BAT_W'(NUM_BATCH - 1));
    last_slot    = last_batch ? SLOT_W'(LAST_FILL - 1) : SLOT_W'(MAXW - 1);
    for (int k = 0; k < MAXW; k++) begin
      batch_mask[k] = !last_batch || (k < LAST_FILL);
    end
    wdog_expired = (wdog_q == WDOG_W'(WDOG_LIMIT - 1));
    scan_end     = pe_done || wdog_expired;
    scan_hit     = pe_done ? pe_hit : '0;
    acc_next     = acc_q | (scan_hit & batch_mask);
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      batch_q     <= '0;
      slot_q      <= '0;
      str_q       <= '0;
      wdog_q      <= '0;
      acc_q       <= '0;
      wt_idx_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      wt_valid_q  <= 1'b0;
      pe_start_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_mask_q  <= '0;
    end else begin
      done_q     <= 1'b0;
      pe_start_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_LOAD;
            busy_q     <= 1'b1;
            error_q    <= 1'b0;
            batch_q    <= '0;
            slot_q     <= '0;
            wt_idx_q   <= '0;
            wt_valid_q <= 1'b1;
          end
        end
        S_LOAD: begin
          // Running global index equals batch*MAXW+slot since batches are packed back to back.
          if (wt_ready) begin
            wt_idx_q <= wt_idx_q + 1'b1;
            if (slot_q == last_slot) begin
              state_q    <= S_SCAN;
              wt_valid_q <= 1'b0;
              slot_q     <= '0;
              acc_q      <= '0;
              str_q      <= '0;
              pe_start_q <= 1'b1;
            end else begin
              slot_q <= slot_q + 1'b1;
            end
          end
        end
        S_SCAN: begin
          wdog_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (scan_end) begin
            acc_q <= acc_next;
            if (!pe_done) error_q <= 1'b1;
            if (str_q == STR_W'(string_num - 1)) begin
              state_q     <= S_WRITE;
              res_valid_q <= 1'b1;
              res_data_q  <= acc_next;
              res_mask_q  <= batch_mask;
            end else begin
              str_q      <= str_q + 1'b1;
              pe_start_q <= 1'b1;
              state_q    <= S_SCAN;
            end
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        S_WRITE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            if (last_batch) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              batch_q    <= batch_q + 1'b1;
              wt_valid_q <= 1'b1;
              state_q    <= S_LOAD;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign wt_valid  = wt_valid_q;
  assign wt_idx    = wt_idx_q;
  assign wt_slot   = slot_q;
  assign pe_start  = pe_start_q;
  assign str_idx   = str_q;
  assign res_valid = res_valid_q;
  assign res_batch = batch_q;
  assign res_data  = res_data_q;
  assign res_mask  = res_mask_q;

endmodule

// File: tb/tb_match_scheduler.sv
// Scoreboard bench for match_scheduler: expectations are queued from a table-driven
// reference model, independent monitors pop and compare on every DUT output event.
module tb_match_scheduler;

  localparam int WN = 10, SN = 3, SL = 4, G = 2, N = 2, MAXW = 4, NB = 3, LAT = 3;
  localparam int WIDX_W = 4, SLOT_W = 2, STR_W = 2, BAT_W = 2;

  logic clk = 1'b0;
  logic reset, start, wt_ready, pe_done, res_ready;
  logic [MAXW-1:0] pe_hit;
  logic busy, done, error, wt_valid, pe_start, res_valid;
  logic [WIDX_W-1:0] wt_idx;
  logic [SLOT_W-1:0] wt_slot;
  logic [STR_W-1:0]  str_idx;
  logic [BAT_W-1:0]  res_batch;
  logic [MAXW-1:0]   res_data, res_mask;

  match_scheduler #(
    .weight_num(WN), .string_num(SN), .strlen(SL), .groups(G), .num(N)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .error(error),
    .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_idx(wt_idx), .wt_slot(wt_slot),
    .pe_start(pe_start), .str_idx(str_idx), .pe_done(pe_done), .pe_hit(pe_hit),
    .res_valid(res_valid), .res_ready(res_ready), .res_batch(res_batch),
    .res_data(res_data), .res_mask(res_mask)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; int slot; } load_t;
  typedef struct { int batch; int data; int mask; } res_t;

  load_t exp_loads[$];
  res_t  exp_res[$];
  int    exp_str[$];

  int n_checks = 0, n_pass = 0;
  int n_loads, n_starts, n_res, n_done, resp_count;
  bit bp_mode = 0, glitch_en = 0, did_pd = 0, did_st = 0;
  logic [MAXW-1:0] hit_tab[NB][SN];
  bit              supp_tab[NB][SN];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_wt_valid"}, wt_valid, 0);
    check({tag, "_wt_idx"}, wt_idx, 0);
    check({tag, "_wt_slot"}, wt_slot, 0);
    check({tag, "_pe_start"}, pe_start, 0);
    check({tag, "_str_idx"}, str_idx, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_batch"}, res_batch, 0);
    check({tag, "_res_data"}, res_data, 0);
    check({tag, "_res_mask"}, res_mask, 0);
  endtask

  // Random hit table; the baseline pattern pins batch 0 and batch 2 to known vectors.
  task automatic setup_tables(input bit baseline);
    for (int b = 0; b < NB; b++)
      for (int s = 0; s < SN; s++) begin
        hit_tab[b][s]  = MAXW'($urandom_range(0, 15));
        supp_tab[b][s] = 1'b0;
      end
    if (baseline) begin
      hit_tab[0][0] = 4'h1; hit_tab[0][1] = 4'h4; hit_tab[0][2] = 4'h0;
      hit_tab[2][0] = 4'hF; hit_tab[2][1] = 4'h0; hit_tab[2][2] = 4'h0;
    end
  endtask

  // Reference model: batch b holds patterns b*MAXW .. min(WN, (b+1)*MAXW)-1.
  task automatic prepare();
    exp_loads.delete(); exp_str.delete(); exp_res.delete();
    n_loads = 0; n_starts = 0; n_res = 0; n_done = 0; resp_count = 0;
    for (int i = 0; i < WN; i++) exp_loads.push_back('{idx: i, slot: i % MAXW});
    for (int b = 0; b < NB; b++) begin
      int fill, mask, data;
      fill = (WN - b * MAXW < MAXW) ? WN - b * MAXW : MAXW;
      mask = (1 << fill) - 1;
      data = 0;
      for (int s = 0; s < SN; s++) begin
        exp_str.push_back(s);
        if (!supp_tab[b][s]) data = data | (int'(hit_tab[b][s]) & mask);
      end
      exp_res.push_back('{batch: b, data: data, mask: mask});
    end
  endtask

  task automatic kick();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("busy_after_start", busy, 1);
  endtask

  task automatic finish_run(input string tag, input bit expect_err);
    int cyc = 0;
    while (n_done == 0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_run_completes"}, n_done > 0, 1);
    repeat (4) @(negedge clk);
    check({tag, "_load_count"}, n_loads, WN);
    check({tag, "_pe_start_count"}, n_starts, NB * SN);
    check({tag, "_result_count"}, n_res, NB);
    check({tag, "_done_count"}, n_done, 1);
    check({tag, "_loads_left"}, exp_loads.size(), 0);
    check({tag, "_results_left"}, exp_res.size(), 0);
    check({tag, "_error"}, error, expect_err);
    check({tag, "_busy_idle"}, busy, 0);
  endtask

  // Weight-load monitor with hold checks under backpressure.
  initial begin
    bit wt_hold = 0;
    int h_idx = 0, h_slot = 0;
    load_t l;
    forever begin
      @(negedge clk);
      if (wt_hold) begin
        check("wt_valid_hold", wt_valid, 1);
        check("wt_idx_hold", wt_idx, h_idx);
        check("wt_slot_hold", wt_slot, h_slot);
      end
      if (wt_valid && wt_ready) begin
        n_loads++;
        if (exp_loads.size() == 0) check("load_unexpected", wt_valid, 0);
        else begin
          l = exp_loads.pop_front();
          check("wt_idx", wt_idx, l.idx);
          check("wt_slot", wt_slot, l.slot);
        end
      end
      wt_hold = wt_valid && !wt_ready;
      h_idx = int'(wt_idx);
      h_slot = int'(wt_slot);
    end
  end

  // Result, pe_start and done monitors.
  initial begin
    bit res_hold = 0, prev_ps = 0;
    int h_b = 0, h_d = 0, h_m = 0;
    res_t r;
    forever begin
      @(negedge clk);
      if (res_hold) begin
        check("res_valid_hold", res_valid, 1);
        check("res_batch_hold", res_batch, h_b);
        check("res_data_hold", res_data, h_d);
        check("res_mask_hold", res_mask, h_m);
      end
      if (res_valid && res_ready) begin
        n_res++;
        if (exp_res.size() == 0) check("res_unexpected", res_valid, 0);
        else begin
          r = exp_res.pop_front();
          check("res_batch", res_batch, r.batch);
          check("res_data", res_data, r.data);
          check("res_mask", res_mask, r.mask);
        end
      end
      res_hold = res_valid && !res_ready;
      h_b = int'(res_batch); h_d = int'(res_data); h_m = int'(res_mask);
      if (pe_start) begin
        n_starts++;
        check("pe_start_single", prev_ps, 0);
        if (exp_str.size() == 0) check("pe_start_unexpected", pe_start, 0);
        else check("str_idx", str_idx, exp_str.pop_front());
      end
      prev_ps = pe_start;
      if (done) begin
        n_done++;
        check("busy_low_with_done", busy, 0);
      end
    end
  end

  // PE array model: answers each scan LAT cycles later, or stays silent for suppressed scans.
  initial begin
    int p, b, s;
    pe_done = 1'b0;
    pe_hit  = '0;
    forever begin
      @(negedge clk);
      if (pe_start) begin
        p = resp_count;
        resp_count++;
        b = (p / SN < NB) ? p / SN : NB - 1;
        s = p % SN;
        if (supp_tab[b][s]) begin
          repeat (SL + 8) @(negedge clk);
          check("wdog_not_early", error, 0);
          @(posedge clk); #1;
          check("wdog_error_set", error, 1);
        end else begin
          repeat (LAT) @(posedge clk);
          #1 pe_done = 1'b1; pe_hit = hit_tab[b][s];
          @(posedge clk);
          #1 pe_done = 1'b0; pe_hit = '0;
        end
      end
    end
  end

  // Events the scheduler must ignore: pe_done during a load and start during a scan.
  initial begin
    forever begin
      @(negedge clk);
      if (glitch_en && !did_pd && wt_valid && n_res == 1) begin
        did_pd = 1'b1;
        pe_done = 1'b1; pe_hit = '1;
        @(posedge clk);
        #1 pe_done = 1'b0; pe_hit = '0;
      end else if (glitch_en && !did_st && pe_start) begin
        did_st = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    end
  end

  // Ready drivers: wt_ready low 5 then high 1..3 cycles; res_ready low 7 then high 1.
  initial begin
    int wt_ph = 0, wt_hi = 2, res_ph = 0;
    wt_ready = 1'b1;
    res_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (!bp_mode) begin
        wt_ready = 1'b1;
        res_ready = 1'b1;
      end else begin
        wt_ready = (wt_ph >= 5);
        wt_ph++;
        if (wt_ph >= 5 + wt_hi) begin
          wt_ph = 0;
          wt_hi = $urandom_range(1, 3);
        end
        res_ready = (res_ph == 7);
        res_ph = (res_ph == 7) ? 0 : res_ph + 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish before %0t", $time);
    $fatal(1);
  end

  initial begin
    int cyc;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 reset = 1'b0;

    setup_tables(1);
    prepare();
    kick();
    finish_run("baseline", 0);

    bp_mode = 1'b1;
    setup_tables(0);
    prepare();
    kick();
    finish_run("backpressure", 0);
    bp_mode = 1'b0;

    setup_tables(0);
    supp_tab[1][1] = 1'b1;
    prepare();
    kick();
    finish_run("watchdog", 1);

    setup_tables(1);
    prepare();
    kick();
    cyc = 0;
    while (resp_count < SN + 1 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    check("midrun_reached_batch1", resp_count >= SN + 1, 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_all_zero("midrun_reset");
    repeat (8) @(negedge clk);
    check("midrun_stays_idle", busy, 0);
    prepare();
    kick();
    finish_run("after_reset", 0);

    setup_tables(0);
    prepare();
    glitch_en = 1'b1;
    kick();
    finish_run("ignored_events", 0);
    glitch_en = 1'b0;
    check("glitch_pe_done_issued", did_pd, 1);
    check("glitch_start_issued", did_st, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/match_scheduler.md
Name: match_scheduler

Overview:
- Sequences the parallel string-matching PE array of `System`.
- Splits the `weight_num` patterns into batches of `max_number_of_weight` (groups×num) PE slots.
- For each batch: loads the batch's weights into the slots, runs every string past the array, OR-accumulates the per-slot hit flags, and writes one masked result word per batch.
- Sits between the weight/string memories, the PE array, and the result register.

Parameters:
- weight_num, 23331, total patterns.
- string_num, 25, strings scanned per batch.
- strlen, 150, characters per string; sets the PE watchdog.
- groups, 4, PE groups.
- num, 4, PEs per group.
- max_number_of_weight, num*groups, slots per batch (MAXW).
- WIDX_W, $clog2(weight_num), weight index width (15).
- SLOT_W, $clog2(max_number_of_weight), slot index width (4).
- STR_W, $clog2(string_num), string index width (5).
- BAT_W, $clog2((weight_num+MAXW-1)/MAXW), batch index width (11).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a full run when idle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last result write.
- error  out  1  sticky PE watchdog flag; cleared by reset or an accepted start.
- wt_valid  out  1  weight load request.
- wt_ready  in  1  weight memory accepted the load.
- wt_idx  out  WIDX_W  global weight index.
- wt_slot  out  SLOT_W  destination PE slot.
- pe_start  out  1  one-cycle pulse; PE array scans string str_idx.
- str_idx  out  STR_W  string index, stable from pe_start until pe_done.
- pe_done  in  1  one-cycle pulse; PE scan complete.
- pe_hit  in  MAXW  per-slot match flags, valid when pe_done=1.
- res_valid  out  1  result word valid.
- res_ready  in  1  result sink accepted the word.
- res_batch  out  BAT_W  batch index of the word.
- res_data  out  MAXW  accumulated hits, masked.
- res_mask  out  MAXW  valid slots in the batch.

Behaviour:
- Reset (synchronous, active-high, honoured in any state, including mid-run):
  - state returns to IDLE; all counters clear.
  - all outputs are 0, including error.
  - no partial result is written.
- States: IDLE, LOAD, SCAN, WAIT, WRITE, DONE.
- IDLE:
  - start=1 → LOAD, batch=0, error cleared.
  - start in any other state is ignored.
- Batch fill: n_b = min(MAXW, weight_num − batch·MAXW); res_mask bit k = (k < n_b).
- LOAD:
  - wt_valid=1, wt_idx = batch·MAXW + slot, wt_slot = slot.
  - wt_idx and wt_slot hold stable while wt_ready=0.
  - On wt_valid&wt_ready: slot increments. When slot == n_b−1 → SCAN with slot=0, hit accumulator=0, str=0.
  - Unused slots are never loaded.
- SCAN:
  - Drives pe_start=1 for exactly one cycle with str_idx=str → WAIT.
  - Watchdog counter starts at 0.
- WAIT:
  - On pe_done: acc |= pe_hit & res_mask.
  - If str == string_num−1 → WRITE; else str++ → SCAN.
  - Watchdog: if pe_done has not arrived after strlen+8 cycles in WAIT, set error=1, treat as pe_done with pe_hit=0, and continue.
  - pe_done outside WAIT is ignored.
- WRITE:
  - res_valid=1, res_batch=batch, res_data=acc, res_mask as above; all held until res_ready.
  - On handshake: if batch is the last batch → DONE; else batch++ → LOAD.
- DONE: done=1 for one cycle, busy falls in the same cycle → IDLE.
- Latency per batch: n_b load handshakes + string_num×(1 + PE latency) + 1 write handshake. No overlap between batches.
- Defaults give 1459 batches (1458 full batches + one final batch with n_b=3, res_mask=0x0007). Batch counter must not wrap.

Test Plan (bench overrides: weight_num=10, groups=2, num=2, MAXW=4, string_num=3, strlen=4):
- Baseline run. Start pulse, wt_ready=1, model pe_done 3 cycles after pe_start:
  - exactly 10 wt loads with wt_idx 0..9, wt_slot 0,1,2,3,0,1,2,3,0,1.
  - 9 pe_start pulses total.
  - 3 result writes, res_batch 0,1,2; res_mask 0xF, 0xF, 0x3.
  - done pulses once.
- Hit accumulation. pe_hit = 0x1, 0x4, 0x0 for strings 0..2 of batch 0 → res_data=0x5. In batch 2, pe_hit=0xF → res_data=0x3 (masked).
- Backpressure. wt_ready low 5 cycles and res_ready low 7 cycles → wt_idx/wt_slot/res_* stable throughout, with no duplicate or skipped loads or writes.
- Watchdog. Suppress pe_done for string 1 of batch 1 → error=1 after 12 WAIT cycles; scan continues; that string contributes 0 hits; run completes with done.
- Reset mid-run. Assert reset in WAIT of batch 1 → next cycle all outputs are 0 and state is IDLE. A new start then reproduces the baseline run.
- Ignored events. start during SCAN and a spurious pe_done in LOAD → no effect on counters or outputs.
